// File: rtl/hdng_err_pipe_pkg.sv
// hdng_err_pkg: shared types and widths for the heading error stage.
//   err_state_t : settle FSM encoding (IDLE, SETTLE, RUN)
//   HDNG_W      : heading sample width (signed)
//   DIFF_W      : raw difference width, one bit wider than a heading
//   ERR_W       : saturated error width delivered to the PID terms
package hdng_err_pkg;
   localparam int ERR_W   = 10;
   localparam int HDNG_W  = 12;
   localparam int DIFF_W  = 13;
   localparam int ERR_MAX = 511;
   localparam int ERR_MIN = -512;

   typedef enum logic [1:0] {IDLE, SETTLE, RUN} err_state_t;
endpackage

// File: rtl/hdng_err_pipe_sat10.sv
// sat10: combinational signed saturator, DIFF_W bits in -> ERR_W bits out.
//   diff : signed input value
//   sat  : diff clamped to [ERR_MIN, ERR_MAX]
module sat10
   import hdng_err_pkg::*;
(
   input  logic signed [DIFF_W-1:0] diff,
   output logic signed [ERR_W-1:0]  sat
);
   localparam logic signed [DIFF_W-1:0] HI = DIFF_W'(ERR_MAX);
   localparam logic signed [DIFF_W-1:0] LO = DIFF_W'(ERR_MIN);

   always_comb begin
      sat = diff[ERR_W-1:0];
      if (diff > HI)
         sat = ERR_W'(ERR_MAX);
      else if (diff < LO)
         sat = ERR_W'(ERR_MIN);
   end
endmodule

// File: rtl/hdng_err_pipe.sv
// hdng_err_pipe: upstream error stage of the heading PID controller.
// Two-stage pipeline: stage 1 forms actl - dsrd, stage 2 saturates to 10
// bits. A settle FSM hides err_vld for SETTLE_SMPLS samples after moving
// rises so the integrator never sees start-up transients.
// Optional feature macro: HDNG_ERR_AVG_EN (4-sample moving average of the
// difference in stage 1; latency unchanged).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   hdng_vld   : one-cycle strobe, new heading sample
//   actl_hdng  : signed measured heading
//   dsrd_hdng  : signed desired heading
//   moving     : motion enable; low returns the FSM to IDLE
//   err_sat    : signed saturated error, registered, updates in every state
//   err_vld    : one-cycle pulse qualifying err_sat downstream
//   settled    : high while the FSM is in RUN
module hdng_err_pipe
   import hdng_err_pkg::*;
#(
   parameter int SETTLE_SMPLS = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     hdng_vld,
   input  logic signed [HDNG_W-1:0] actl_hdng,
   input  logic signed [HDNG_W-1:0] dsrd_hdng,
   input  logic                     moving,
   output logic signed [ERR_W-1:0]  err_sat,
   output logic                     err_vld,
   output logic                     settled
);
   localparam logic [7:0] CNT_LAST = 8'((SETTLE_SMPLS == 0) ? 0 : SETTLE_SMPLS - 1);

   err_state_t state, state_nxt;
   logic [7:0] cnt, cnt_nxt;

   logic vld_s1, vld_s2;
   logic signed [DIFF_W-1:0] diff_new, sat_in;
   logic signed [ERR_W-1:0]  sat_out;

   // 13-bit result of two sign-extended 12-bit values cannot overflow.
   assign diff_new = {actl_hdng[HDNG_W-1], actl_hdng} - {dsrd_hdng[HDNG_W-1], dsrd_hdng};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_s1 <= 1'b0;
      else        vld_s1 <= hdng_vld;
   end

`ifdef HDNG_ERR_AVG_EN
   localparam int SUM_W = DIFF_W + 2;
   logic signed [DIFF_W-1:0] hist [4];
   logic signed [SUM_W-1:0]  sum_s1;

   // Running sum: add the newest diff, retire the one falling off the end.
   // History is flushed while idle so a restart never averages stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) hist[i] <= '0;
         sum_s1 <= '0;
      end else if (state == IDLE) begin
         for (int i = 0; i < 4; i++) hist[i] <= '0;
         sum_s1 <= '0;
      end else if (hdng_vld) begin
         hist[0] <= diff_new;
         for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
         sum_s1 <= sum_s1 + {{2{diff_new[DIFF_W-1]}}, diff_new}
                          - {{2{hist[3][DIFF_W-1]}}, hist[3]};
      end
   end

   // sum >>> 2 always fits in DIFF_W bits; dropping the low bits is the shift.
   assign sat_in = sum_s1[SUM_W-1:2];
`else
   logic signed [DIFF_W-1:0] diff_s1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        diff_s1 <= '0;
      else if (hdng_vld) diff_s1 <= diff_new;
   end

   assign sat_in = diff_s1;
`endif

   sat10 u_sat (
      .diff (sat_in),
      .sat  (sat_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_s2  <= 1'b0;
         err_sat <= '0;
      end else begin
         vld_s2 <= vld_s1;
         if (vld_s1) err_sat <= sat_out;
      end
   end

   // Settle FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         settled <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         settled <= (state_nxt == RUN);
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (moving) state_nxt = (SETTLE_SMPLS == 0) ? RUN : SETTLE;
         end
         SETTLE: begin
            // The sample that completes settling is still swallowed because
            // err_vld requires state == RUN in the cycle it is presented.
            if (vld_s2) begin
               if (cnt == CNT_LAST) begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 8'd1;
               end
            end
         end
         RUN:     state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
      if (!moving) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end
   end

   // Live moving term kills a pulse in the very cycle motion stops.
   assign err_vld = vld_s2 && (state == RUN) && moving;
endmodule

// File: tb/tb_hdng_err_pipe.sv
// tb_hdng_err_pipe: self-checking bench for hdng_err_pipe (default build).
// A cycle-indexed sample history plus a countdown-of-discards model predicts
// err_sat, err_vld and settled every cycle.
module tb_hdng_err_pipe;
   localparam int S = 4;
   localparam int HMAX = 4096;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic hdng_vld = 1'b0;
   logic signed [11:0] actl_hdng = '0;
   logic signed [11:0] dsrd_hdng = '0;
   logic moving = 1'b0;
   logic signed [9:0] err_sat;
   logic err_vld;
   logic settled;

   hdng_err_pipe #(.SETTLE_SMPLS(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .hdng_vld  (hdng_vld),
      .actl_hdng (actl_hdng),
      .dsrd_hdng (dsrd_hdng),
      .moving    (moving),
      .err_sat   (err_sat),
      .err_vld   (err_vld),
      .settled   (settled)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int  cc = 2;
   bit  hv_h [HMAX];
   int  df_h [HMAX];
   int  mode = 0;      // 0 idle, 1 discarding, 2 running
   int  need = 0;      // samples still to discard
   int  exp_sat = 0;
   int  vld_seen = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cc);
      end
   endtask

   function automatic int sat(input int d);
      if (d > 511)  return 511;
      if (d < -512) return -512;
      return d;
   endfunction

   // One clock cycle: drive at posedge+1, check at negedge, advance model.
   task automatic cyc(input bit hv, input int a, input int d, input bit mv);
      bit v2;
      hdng_vld  = hv;
      actl_hdng = 12'(a);
      dsrd_hdng = 12'(d);
      moving    = mv;
      hv_h[cc % HMAX] = hv;
      df_h[cc % HMAX] = a - d;
      v2 = hv_h[(cc - 2) % HMAX];
      if (v2) exp_sat = sat(df_h[(cc - 2) % HMAX]);
      @(negedge clk);
      chk("err_sat", int'(err_sat), exp_sat);
      chk("err_vld", int'(err_vld), int'(v2 && mode == 2 && mv));
      chk("settled", int'(settled), int'(mode == 2));
      if (err_vld) vld_seen++;
      if (!mv) mode = 0;
      else if (mode == 0) begin
         need = S;
         mode = (S == 0) ? 2 : 1;
      end else if (mode == 1 && v2) begin
         need--;
         if (need == 0) mode = 2;
      end
      @(posedge clk);
      #1;
      cc++;
   endtask

   // Asynchronous reset in the middle of a cycle with samples in flight.
   task automatic do_reset();
      hdng_vld  = 1'b1;
      actl_hdng = 12'(300);
      rst_n     = 1'b0;
      #1;
      chk("rst_err_sat", int'(err_sat), 0);
      chk("rst_err_vld", int'(err_vld), 0);
      chk("rst_settled", int'(settled), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      hv_h[(cc - 1) % HMAX] = 1'b0;
      hv_h[(cc - 2) % HMAX] = 1'b0;
      exp_sat = 0;
      mode = 0;
      need = 0;
   endtask

   int sat_a [5] = '{2047, -2048, 300, -300, -300};
   int sat_d [5] = '{-2048, 2047, -211, 213, 212};
   int sat_e [5] = '{511, -512, 511, -512, -512};

   initial begin
      for (int i = 0; i < HMAX; i++) begin
         hv_h[i] = 1'b0;
         df_h[i] = 0;
      end
      #1;
      chk("init_err_sat", int'(err_sat), 0);
      chk("init_err_vld", int'(err_vld), 0);
      chk("init_settled", int'(settled), 0);
      @(posedge clk);
      #1;
      do_reset();
      repeat (3) cyc(1'b0, 0, 0, 1'b0);

      // Settle count: six samples, only the last two are forwarded.
      cyc(1'b0, 0, 0, 1'b1);
      cyc(1'b0, 0, 0, 1'b1);
      vld_seen = 0;
      for (int p = 0; p < 6; p++) begin
         cyc(1'b1, 100, 40, 1'b1);
         cyc(1'b0, 0, 0, 1'b1);
         cyc(1'b0, 0, 0, 1'b1);
      end
      chk("settle_fwd_cnt", vld_seen, 2);
      chk("settle_state", int'(settled), 1);
      chk("settle_err", int'(err_sat), 60);

      // Saturation and exact boundaries.
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, sat_a[k], sat_d[k], 1'b1);
         cyc(1'b0, 0, 0, 1'b1);
         cyc(1'b0, 0, 0, 1'b1);
         chk("sat_lit", int'(err_sat), sat_e[k]);
      end

      // Moving drops for one cycle exactly when a sample reaches stage 2.
      cyc(1'b1, 50, 10, 1'b1);
      cyc(1'b0, 0, 0, 1'b1);
      vld_seen = 0;
      cyc(1'b0, 0, 0, 1'b0);
      chk("drop_gate", vld_seen, 0);
      chk("drop_settled", int'(settled), 0);
      vld_seen = 0;
      for (int p = 0; p < 6; p++) begin
         cyc(1'b1, -70, 30, 1'b1);
         cyc(1'b0, 0, 0, 1'b1);
      end
      cyc(1'b0, 0, 0, 1'b1);
      cyc(1'b0, 0, 0, 1'b1);
      chk("resettle_cnt", vld_seen, 2);

      // Throughput: back-to-back samples with a ramping heading.
      vld_seen = 0;
      for (int i = 0; i < 16; i++) cyc(1'b1, -400 + 60 * i, 25, 1'b1);
      cyc(1'b0, 0, 0, 1'b1);
      cyc(1'b0, 0, 0, 1'b1);
      chk("thru_cnt", vld_seen, 16);

      // Reset mid-stream, then confirm nothing leaks out afterwards.
      cyc(1'b1, 5, 1, 1'b1);
      do_reset();
      vld_seen = 0;
      repeat (3) cyc(1'b0, 0, 0, 1'b1);
      chk("post_rst_vld", vld_seen, 0);

      // Randomized traffic with occasional motion drops.
      begin
         int drop = 0;
         for (int i = 0; i < 1500; i++) begin
            bit hv, mv;
            int a, d;
            hv = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
               a = $urandom_range(0, 4095) - 2048;
               d = $urandom_range(0, 4095) - 2048;
            end else begin
               a = $urandom_range(0, 1200) - 600;
               d = a - ($urandom_range(0, 1100) - 550);
               if (d > 2047) d = 2047;
               if (d < -2048) d = -2048;
            end
            if (drop == 0 && $urandom_range(0, 39) == 0) drop = $urandom_range(1, 3);
            mv = (drop == 0);
            if (drop > 0) drop--;
            cyc(hv, a, d, mv);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/hdng_err_pipe.md
Name: hdng_err_pipe

Overview:
Upstream error stage of the heading PID controller.
- Samples actual and desired heading on each sensor-valid strobe and forms the signed error.
- Saturates the error to 10 bits and delivers it with a one-cycle valid pulse to the I/D/P term blocks (err_sat, err_vld).
- After `moving` rises, suppresses err_vld for a programmable number of samples so the integrator does not accumulate start-up transients.

Parameters:
SETTLE_SMPLS, 4, number of valid samples discarded after `moving` rises (0 = no settling; legal range 0..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
hdng_vld  input  1  one-cycle strobe; new heading sample present
actl_hdng  input  12  signed measured heading
dsrd_hdng  input  12  signed desired heading
moving  input  1  motion enable; low forces IDLE
err_sat  output  10  signed saturated error, registered
err_vld  output  1  one-cycle pulse; err_sat valid for downstream accumulation
settled  output  1  high while in RUN state

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - err_sat = 0, err_vld = 0, settled = 0.
  - Pipeline registers and valids = 0; settle counter = 0; state = IDLE.
- Stage 1, on clk when hdng_vld = 1:
  - diff_s1 <= sext13(actl_hdng) - sext13(dsrd_hdng); this is 13-bit signed and cannot overflow.
  - vld_s1 <= hdng_vld every cycle.
- Stage 2, every clk:
  - vld_s2 <= vld_s1.
  - If vld_s1, err_sat <= sat10(diff_s1); otherwise err_sat holds.
- sat10 rule: diff > 511 -> 0x1FF (511); diff < -512 -> 0x200 (-512); otherwise diff[9:0].
- Latency: hdng_vld at edge N -> err_sat updated and vld_s2 high after edge N+2, i.e. 2 cycles.
- Back-to-back hdng_vld every cycle is supported: full throughput, no bubbles.
- err_vld = vld_s2 && (state == RUN) && moving. This is a combinational AND of registered signals and `moving`.
- err_sat keeps updating in all states. Only err_vld is gated.
- State machine (IDLE, SETTLE, RUN):
  - IDLE: counter cleared.
    - moving = 1 and SETTLE_SMPLS = 0 -> RUN.
    - moving = 1 and SETTLE_SMPLS > 0 -> SETTLE.
  - SETTLE: on each vld_s2, counter increments.
    - When vld_s2 and counter == SETTLE_SMPLS-1 -> RUN.
    - The completing pulse is NOT forwarded.
  - RUN: stays while moving = 1.
  - Any state with moving = 0 -> IDLE at the next edge. Counter is cleared.
- Boundary conditions:
  - vld_s2 in the cycle the FSM is still IDLE (same edge moving rose) is not counted.
  - moving falls while RUN and vld_s2 is high in the same cycle: err_vld = 0 because of the combinational gate.
  - moving toggles low for one cycle: full re-settle of SETTLE_SMPLS samples.
  - hdng_vld while rst_n is low: ignored. In-flight samples are dropped on reset; no residual err_vld after release.
- settled = (state == RUN), registered.

Optional Feature:
HDNG_ERR_AVG_EN
- Defined:
  - Stage 1 keeps a 4-deep history of 13-bit diffs, shifted on hdng_vld, and a 15-bit signed running sum.
  - Stage 2 saturates (sum >>> 2), an arithmetic shift.
  - History and sum are cleared while state == IDLE.
  - Latency is unchanged (2 cycles).
- Undefined: stage 1 passes the single diff as described above. No history registers are synthesized.

Decomposition:
- Package hdng_err_pkg:
  - typedef enum logic [1:0] {IDLE, SETTLE, RUN} err_state_t
  - localparams ERR_W = 10, HDNG_W = 12, DIFF_W = 13, ERR_MAX = 511, ERR_MIN = -512
- Sub-module sat10: combinational DIFF_W -> ERR_W signed saturator. It is reused by the optional averaging path.

Test Plan:
- Reset check:
  - Stimulus: assert rst_n low mid-stream with hdng_vld pulsing.
  - Response: err_sat = 0, err_vld = 0 and settled = 0 immediately (async). No err_vld within 3 cycles after release.
- Settle count:
  - Stimulus: SETTLE_SMPLS = 4, moving = 1, six hdng_vld pulses with actl = 100, dsrd = 40.
  - Response: pulses 1-4 give no err_vld. settled rises after pulse 4 reaches stage 2. Pulses 5 and 6 give err_vld with err_sat = 60, two cycles after each hdng_vld.
- Saturation:
  - actl = 2047, dsrd = -2048 -> 511
  - actl = -2048, dsrd = 2047 -> -512
  - actl = 300, dsrd = -211 -> 511 exactly
  - actl = -300, dsrd = 213 -> -512 exactly
  - actl = -300, dsrd = 212 -> -512 (unsaturated boundary)
- Moving drop:
  - Stimulus: in RUN, deassert moving for one cycle coincident with vld_s2, then reassert.
  - Response: err_vld = 0 on that cycle. settled = 0 the next cycle. Four new samples are discarded before err_vld resumes.
- Throughput: hdng_vld held high for 16 cycles with ramping actl. After settling, err_vld is high every cycle and err_sat tracks actl - dsrd delayed by 2 cycles.
- HDNG_ERR_AVG_EN:
  - Stimulus: diffs 40, 80, 120, 160 in RUN.
  - Response: the 4th output is 100. Diffs of 2047 repeated saturate to 511.
